fetch_sched: RTL and testbench

//  Sequences word fetches from the feature RAM and unpacks each WORD_W-bit word into FIELD_W-bit

---
 rtl/fetch_pkg.sv | 18 +
 rtl/fetch_sched_field_unpacker.sv | 47 ++++
 rtl/fetch_sched.sv | 171 +++++++++++++++++
 tb/tb_fetch_sched.sv | 232 +++++++++++++++++++++++
 4 files changed

// File: rtl/fetch_pkg.sv
// fetch_pkg: shared state encoding, default sizes and sizing helpers for fetch_sched.
package fetch_pkg;

  typedef enum logic [2:0] {IDLE, READ, WAIT, SHIFT, DONE} state_e;

  localparam int WORD_W_DEF  = 20;
  localparam int FIELD_W_DEF = 5;
  localparam int ADDR_W_DEF  = 8;

  function automatic int fields_of(input int word_w, input int field_w);
    return word_w / field_w;
  endfunction

  function automatic int cnt_w_of(input int fields);
    return (fields > 1) ? $clog2(fields) : 1;
  endfunction

endpackage

// File: rtl/fetch_sched_field_unpacker.sv
// field_unpacker: holds one RAM word and presents it MSB field first; load wins over shift.
module field_unpacker import fetch_pkg::*; #(
  parameter  int WORD_W  = WORD_W_DEF,
  parameter  int FIELD_W = FIELD_W_DEF,
  localparam int FIELDS  = fields_of(WORD_W, FIELD_W),
  localparam int CNT_W   = cnt_w_of(FIELDS)
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               load,
  input  logic [WORD_W-1:0]  load_data,
  input  logic               shift,
  output logic [FIELD_W-1:0] field,
  output logic [CNT_W-1:0]   field_cnt,
  output logic               last_field
);

  logic [WORD_W-1:0] sr_q, sr_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;

  always_comb begin
    sr_d  = sr_q;
    cnt_d = cnt_q;
    if (load) begin
      sr_d  = load_data;
      cnt_d = '0;
    end else if (shift) begin
      sr_d  = sr_q << FIELD_W;
      cnt_d = cnt_q + CNT_W'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      sr_q  <= '0;
      cnt_q <= '0;
    end else begin
      sr_q  <= sr_d;
      cnt_q <= cnt_d;
    end
  end

  assign field      = sr_q[WORD_W-1 -: FIELD_W];
  assign field_cnt  = cnt_q;
  assign last_field = (cnt_q == CNT_W'(FIELDS-1));

endmodule

// File: rtl/fetch_sched.sv
// fetch_sched: fetches a frame of RAM words and streams their fields MSB first.
// Optional FETCH_PREFETCH_EN overlaps the next word's read with the current word's fields.
//
//   state | meaning
//   IDLE  | waiting for start
//   READ  | RAM read strobe for word word_idx
//   WAIT  | RAM data returns, load unpacker
//   SHIFT | stream fields of the current word
//   DONE  | one-cycle frame completion pulse
module fetch_sched import fetch_pkg::*; #(
  parameter int WORD_W  = WORD_W_DEF,
  parameter int FIELD_W = FIELD_W_DEF,
  parameter int ADDR_W  = ADDR_W_DEF
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               start,
  input  logic [ADDR_W-1:0]  base_addr,
  input  logic [ADDR_W:0]    num_words,
  output logic               busy,
  output logic               done,
  output logic               mem_rd_en,
  output logic [ADDR_W-1:0]  mem_addr,
  input  logic [WORD_W-1:0]  mem_rdata,
  output logic               out_valid,
  input  logic               out_ready,
  output logic [FIELD_W-1:0] out_data,
  output logic               out_last
);

  localparam int FIELDS = fields_of(WORD_W, FIELD_W);
  localparam int CNT_W  = cnt_w_of(FIELDS);

  state_e             state_q, state_d;
  logic [ADDR_W-1:0]  base_q, base_d;
  logic [ADDR_W:0]    num_q, num_d;
  logic [ADDR_W:0]    widx_q, widx_d;

  logic               load, shift, last_field, last_word, hs;
  logic [WORD_W-1:0]  load_data;
  logic [FIELD_W-1:0] field;
  logic [CNT_W-1:0]   field_cnt;
  logic [ADDR_W-1:0]  rd_addr;

`ifdef FETCH_PREFETCH_EN
  logic              pf_issued_q, pf_issued_d;
  logic              pf_cap_q, pf_cap_d;
  logic [WORD_W-1:0] pf_data_q, pf_data_d;
`endif

  assign last_word = ((widx_q + (ADDR_W+1)'(1)) == num_q);
  assign hs        = out_valid && out_ready;

  always_comb begin
    state_d   = state_q;
    base_d    = base_q;
    num_d     = num_q;
    widx_d    = widx_q;
    load      = 1'b0;
    shift     = 1'b0;
    load_data = mem_rdata;
    mem_rd_en = 1'b0;
    rd_addr   = base_q + widx_q[ADDR_W-1:0];
`ifdef FETCH_PREFETCH_EN
    pf_issued_d = pf_issued_q;
    pf_cap_d    = 1'b0;
    pf_data_d   = pf_cap_q ? mem_rdata : pf_data_q;
`endif
    case (state_q)
      IDLE: begin
        if (start) begin
          base_d  = base_addr;
          num_d   = num_words;
          widx_d  = '0;
          state_d = (num_words == '0) ? DONE : READ;
`ifdef FETCH_PREFETCH_EN
          pf_issued_d = 1'b0;
`endif
        end
      end
      READ: begin
        mem_rd_en = 1'b1;
        state_d   = WAIT;
      end
      WAIT: begin
        load    = 1'b1;
        state_d = SHIFT;
      end
      SHIFT: begin
`ifdef FETCH_PREFETCH_EN
        // One early read per word, timed so the data lands by the last field.
        if (!pf_issued_q && !last_word && (field_cnt == CNT_W'(FIELDS-2))) begin
          mem_rd_en   = 1'b1;
          rd_addr     = base_q + widx_q[ADDR_W-1:0] + ADDR_W'(1);
          pf_issued_d = 1'b1;
          pf_cap_d    = 1'b1;
        end
`endif
        if (hs) begin
          shift = 1'b1;
          if (last_field) begin
            if (last_word) begin
              state_d = DONE;
            end else begin
              widx_d = widx_q + (ADDR_W+1)'(1);
`ifdef FETCH_PREFETCH_EN
              load        = 1'b1;
              load_data   = pf_cap_q ? mem_rdata : pf_data_q;
              pf_issued_d = 1'b0;
`else
              state_d = READ;
`endif
            end
          end
        end
      end
      DONE: state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      base_q  <= '0;
      num_q   <= '0;
      widx_q  <= '0;
    end else begin
      state_q <= state_d;
      base_q  <= base_d;
      num_q   <= num_d;
      widx_q  <= widx_d;
    end
  end

`ifdef FETCH_PREFETCH_EN
  always_ff @(posedge clk) begin
    if (rst) begin
      pf_issued_q <= 1'b0;
      pf_cap_q    <= 1'b0;
      pf_data_q   <= '0;
    end else begin
      pf_issued_q <= pf_issued_d;
      pf_cap_q    <= pf_cap_d;
      pf_data_q   <= pf_data_d;
    end
  end
`endif

  field_unpacker #(
    .WORD_W  (WORD_W),
    .FIELD_W (FIELD_W)
  ) u_unpacker (
    .clk        (clk),
    .rst        (rst),
    .load       (load),
    .load_data  (load_data),
    .shift      (shift),
    .field      (field),
    .field_cnt  (field_cnt),
    .last_field (last_field)
  );

  assign busy      = (state_q != IDLE);
  assign done      = (state_q == DONE);
  assign out_valid = (state_q == SHIFT);
  assign out_data  = out_valid ? field : '0;
  assign out_last  = out_valid && last_word && (field_cnt == CNT_W'(FIELDS-1));
  assign mem_addr  = mem_rd_en ? rd_addr : '0;

endmodule

// File: tb/tb_fetch_sched.sv
// tb_fetch_sched: scoreboard bench for fetch_sched with a 1-cycle-latency RAM model.
module tb_fetch_sched;

  localparam int WORD_W  = 20;
  localparam int FIELD_W = 5;
  localparam int ADDR_W  = 8;
  localparam int FIELDS  = WORD_W / FIELD_W;

  logic              clk = 1'b0;
  logic              rst;
  logic              start;
  logic [ADDR_W-1:0] base_addr;
  logic [ADDR_W:0]   num_words;
  logic              busy, done, mem_rd_en, out_valid, out_last;
  logic              out_ready;
  logic [ADDR_W-1:0] mem_addr;
  logic [WORD_W-1:0] mem_rdata = '0;
  logic [FIELD_W-1:0] out_data;

  logic [WORD_W-1:0] mem [256];
  logic [5:0]        exp_field[$];
  logic [7:0]        exp_addr[$];

  int n_checks = 0;
  int n_fail   = 0;
  int cyc      = 0;
  int start_cyc, first_rd, first_valid;
  int ready_mode = 0;
  bit prev_valid, prev_ready, prev_last;
  logic [FIELD_W-1:0] prev_data;

  fetch_sched #(.WORD_W(WORD_W), .FIELD_W(FIELD_W), .ADDR_W(ADDR_W)) dut (
    .clk       (clk),
    .rst       (rst),
    .start     (start),
    .base_addr (base_addr),
    .num_words (num_words),
    .busy      (busy),
    .done      (done),
    .mem_rd_en (mem_rd_en),
    .mem_addr  (mem_addr),
    .mem_rdata (mem_rdata),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_data  (out_data),
    .out_last  (out_last)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;
  always @(posedge clk) if (mem_rd_en) mem_rdata <= mem[mem_addr];

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", tag, got, exp, cyc);
    end
  endtask

  function automatic int exp_len(input int n);
    if (n == 0) return 1;
`ifdef FETCH_PREFETCH_EN
    return 3 + FIELDS * n;
`else
    return 1 + (FIELDS + 2) * n;
`endif
  endfunction

  initial begin
    out_ready = 1'b1;
    forever begin
      @(posedge clk); #1;
      case (ready_mode)
        0: out_ready = 1'b1;
        1: out_ready = ~out_ready;
        default: out_ready = 1'($urandom_range(0, 1));
      endcase
    end
  end

  // Scoreboard monitor, sampled mid-cycle.
  always @(negedge clk) begin
    if (rst) begin
      prev_valid = 1'b0;
    end else begin
      if (mem_rd_en) begin
        if (first_rd < 0) first_rd = cyc;
        if (exp_addr.size() == 0) chk("unexpected_read", 1, 0);
        else chk("rd_addr", mem_addr, exp_addr.pop_front());
      end
      if (out_valid && first_valid < 0) first_valid = cyc;
      if (prev_valid && !prev_ready) begin
        chk("stall_valid", out_valid, 1);
        chk("stall_data", out_data, prev_data);
        chk("stall_last", out_last, prev_last);
      end
      if (out_valid && out_ready) begin
        if (exp_field.size() == 0) chk("unexpected_field", 1, 0);
        else chk("field", {out_last, out_data}, exp_field.pop_front());
      end
      prev_valid = out_valid;
      prev_ready = out_ready;
      prev_data  = out_data;
      prev_last  = out_last;
    end
  end

  task automatic push_exp(input logic [7:0] b, input logic [8:0] n);
    logic [7:0]  a;
    logic [19:0] w;
    for (int i = 0; i < int'(n); i++) begin
      a = b + 8'(i);
      w = mem[a];
      exp_addr.push_back(a);
      for (int f = 0; f < FIELDS; f++)
        exp_field.push_back({(f == FIELDS-1) && (i == int'(n) - 1), w[WORD_W-1-FIELD_W*f -: FIELD_W]});
    end
  endtask

  task automatic run_frame(input logic [7:0] b, input logic [8:0] n, input int rmode,
                           input bit timed, input int poke_at);
    bit seen;
    ready_mode = rmode;
    push_exp(b, n);
    @(posedge clk); #1;
    start = 1'b1; base_addr = b; num_words = n;
    start_cyc = cyc; first_rd = -1; first_valid = -1;
    @(posedge clk); #1;
    start = 1'b0;
    seen = 1'b0;
    for (int i = 0; i < 4000 && !seen; i++) begin
      @(negedge clk);
      if (i == poke_at) begin
        start = 1'b1; base_addr = 8'h40; num_words = 9'd5;
      end else begin
        start = 1'b0;
      end
      if (done) seen = 1'b1;
    end
    start = 1'b0;
    chk("done_seen", seen, 1);
    if (seen) begin
      chk("busy_at_done", busy, 1);
      chk("fields_left", exp_field.size(), 0);
      chk("reads_left", exp_addr.size(), 0);
      if (timed) chk("frame_len", cyc - start_cyc, exp_len(int'(n)));
      if (n == 0) begin
        chk("no_read", first_rd, -1);
        chk("no_valid", first_valid, -1);
      end else if (timed) begin
        chk("rd_latency", first_rd - start_cyc, 1);
        chk("valid_latency", first_valid - start_cyc, 3);
      end
    end
    @(negedge clk);
    chk("done_pulse", done, 0);
    chk("busy_after", busy, 0);
    exp_field.delete();
    exp_addr.delete();
  endtask

  initial begin
    bit hit, saw_done;
    for (int i = 0; i < 256; i++) mem[i] = 20'(i * 32'h1F3A7 + 32'h5C1);
    mem[8'h20] = 20'hFAC31;
    rst = 1'b1; start = 1'b0; base_addr = '0; num_words = '0;
    first_rd = -1; first_valid = -1;
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("rst_busy", busy, 0);
    chk("rst_done", done, 0);
    chk("rst_rd_en", mem_rd_en, 0);
    chk("rst_valid", out_valid, 0);
    chk("rst_last", out_last, 0);
    chk("rst_addr", mem_addr, 0);
    chk("rst_data", out_data, 0);
    rst = 1'b0;

    run_frame(8'h10, 9'd3, 0, 1'b1, -1);
    run_frame(8'h20, 9'd1, 0, 1'b1, -1);
    run_frame(8'h50, 9'd3, 1, 1'b0, -1);
    run_frame(8'h77, 9'd0, 0, 1'b1, -1);
    run_frame(8'hFE, 9'd3, 0, 1'b1, 5);
    run_frame(8'h80, 9'd4, 2, 1'b0, -1);

    // Reset while streaming the third word, then a clean frame.
    ready_mode = 0;
    push_exp(8'h30, 9'd3);
    @(posedge clk); #1;
    start = 1'b1; base_addr = 8'h30; num_words = 9'd3;
    @(posedge clk); #1;
    start = 1'b0;
    hit = 1'b0;
    for (int i = 0; i < 200 && !hit; i++) begin
      @(negedge clk);
      if (out_valid && exp_field.size() <= 3) hit = 1'b1;
    end
    chk("rst_reach", hit, 1);
    rst = 1'b1;
    @(negedge clk);
    chk("mid_rst_busy", busy, 0);
    chk("mid_rst_done", done, 0);
    chk("mid_rst_rd_en", mem_rd_en, 0);
    chk("mid_rst_valid", out_valid, 0);
    chk("mid_rst_last", out_last, 0);
    chk("mid_rst_data", out_data, 0);
    chk("mid_rst_addr", mem_addr, 0);
    rst = 1'b0;
    exp_field.delete();
    exp_addr.delete();
    saw_done = 1'b0;
    repeat (6) begin
      @(negedge clk);
      if (done) saw_done = 1'b1;
    end
    chk("no_done_after_rst", saw_done, 0);
    run_frame(8'h30, 9'd3, 0, 1'b1, -1);

    run_frame(8'h05, 9'd256, 0, 1'b1, -1);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish, got cycle %0d expected completion", cyc);
    $fatal(1);
  end

endmodule
